// File: rtl/fp8_dot_accumulator.sv
// FP8 dot-product accumulator.
// Takes S/E4/M3 products over a valid/ready stream and sums them in a signed
// fixed-point register that saturates. When the last term arrives, it normalises
// the sum one bit per cycle and returns one FP8 result over a valid/ready handshake.
// ACC_W must be at least 20 so that the largest term, 15 << 15, fits.
module fp8_dot_accumulator #(
    parameter int EXP_BITS      = 4,
    parameter int MANTISSA_BITS = 3,
    parameter int BIAS          = 7,
    parameter int ACC_W         = 24
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [EXP_BITS+MANTISSA_BITS:0]   in_data,
    input  logic                              in_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [EXP_BITS+MANTISSA_BITS:0]   out_data,
    output logic                              out_sat
);
    localparam int FW    = 1 + EXP_BITS + MANTISSA_BITS;
    localparam int POS_W = $clog2(ACC_W);
    localparam int EXP_MAX = (1 << EXP_BITS) - 1;

    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_NORM  = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;

    localparam logic signed [ACC_W:0]   SUM_MAX = (ACC_W+1)'((64'd1 << (ACC_W-1)) - 64'd1);
    localparam logic signed [ACC_W:0]   SUM_MIN = -SUM_MAX;
    localparam logic [POS_W-1:0]        POS_TOP = POS_W'(ACC_W-2);

    logic [1:0]               state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     sat_q, sat_d;
    logic [ACC_W-2:0]         m_q, m_d;
    logic [POS_W-1:0]         pos_q, pos_d;
    logic                     first_q, first_d;
    logic [FW-1:0]            out_data_q, out_data_d;
    logic                     out_sat_q, out_sat_d;

    logic                     term_s;
    logic [EXP_BITS-1:0]      term_e;
    logic [MANTISSA_BITS-1:0] term_m;
    logic signed [ACC_W-1:0]  term_val;
    logic signed [ACC_W:0]    sum_wide;
    logic signed [ACC_W-1:0]  sum_clamped;
    logic                     sum_sat;
    logic [ACC_W-1:0]         acc_abs;
    logic [FW-1:0]            pack_data;
    logic                     pack_exp_sat;

    assign term_s = in_data[FW-1];
    assign term_e = in_data[FW-2:MANTISSA_BITS];
    assign term_m = in_data[MANTISSA_BITS-1:0];

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_OUT);
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    // Convert the incoming term to fixed point and add it to the sum with saturation.
    // E==0 flushes the term to zero.
    always_comb begin
        logic [ACC_W-1:0] mag;
        mag      = ACC_W'({1'b1, term_m}) << term_e;
        term_val = '0;
        if (term_e != '0)
            term_val = term_s ? -$signed(mag) : $signed(mag);
        sum_wide    = {acc_q[ACC_W-1], acc_q} + {term_val[ACC_W-1], term_val};
        sum_sat     = 1'b0;
        sum_clamped = ACC_W'(sum_wide);
        if (sum_wide > SUM_MAX) begin
            sum_clamped = ACC_W'(SUM_MAX);
            sum_sat     = 1'b1;
        end else if (sum_wide < SUM_MIN) begin
            sum_clamped = ACC_W'(SUM_MIN);
            sum_sat     = 1'b1;
        end
        // The clamp is symmetric, so |acc| always fits in ACC_W-1 bits.
        acc_abs = acc_q[ACC_W-1] ? ACC_W'(-acc_q) : ACC_W'(acc_q);
    end

    // Build the FP8 encoding from the normalised magnitude.
    // The MSB sits at bit pos with LSB weight 2^-(BIAS+M), so the biased exponent is pos-(BIAS+M)+BIAS.
    always_comb begin
        int e_int;
        e_int        = int'(pos_q) - (BIAS + MANTISSA_BITS) + BIAS;
        pack_exp_sat = 1'b0;
        if (m_q == '0 || e_int < 0) begin
            pack_data = '0;
        end else if (e_int > EXP_MAX) begin
            pack_data    = {acc_q[ACC_W-1], {(FW-1){1'b1}}};
            pack_exp_sat = 1'b1;
        end else begin
            pack_data = {acc_q[ACC_W-1], EXP_BITS'(e_int), m_q[ACC_W-3 -: MANTISSA_BITS]};
        end
    end

    // Next-state logic for the ACCUM -> NORM -> OUT sequence.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        sat_d      = sat_q;
        m_d        = m_q;
        pos_d      = pos_q;
        first_d    = first_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        case (state_q)
            ST_ACCUM: begin
                if (in_valid) begin
                    acc_d = sum_clamped;
                    if (sum_sat)
                        sat_d = 1'b1;
                    if (in_last) begin
                        state_d = ST_NORM;
                        first_d = 1'b1;
                    end
                end
            end
            ST_NORM: begin
                if (first_q) begin
                    m_d     = acc_abs[ACC_W-2:0];
                    pos_d   = POS_TOP;
                    first_d = 1'b0;
                end else if (m_q == '0 || m_q[ACC_W-2]) begin
                    out_data_d = pack_data;
                    out_sat_d  = sat_q | pack_exp_sat;
                    sat_d      = sat_q | pack_exp_sat;
                    state_d    = ST_OUT;
                end else begin
                    m_d   = m_q << 1;
                    pos_d = pos_q - 1'b1;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    acc_d   = '0;
                    sat_d   = 1'b0;
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    // State registers. Reset discards any sum or result that is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ACCUM;
            acc_q      <= '0;
            sat_q      <= 1'b0;
            m_q        <= '0;
            pos_q      <= POS_TOP;
            first_q    <= 1'b0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            sat_q      <= sat_d;
            m_q        <= m_d;
            pos_q      <= pos_d;
            first_q    <= first_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end
endmodule

// File: tb/tb_fp8_dot_accumulator.sv
// Directed testbench for fp8_dot_accumulator. Expected values are computed by hand.
module tb_fp8_dot_accumulator;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_sat;

    int checks = 0;
    int errors = 0;

    fp8_dot_accumulator dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one term; in ACCUM it is accepted at the next rising edge.
    task automatic send(input logic [7:0] d, input logic last);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'($urandom);
    endtask

    // Measure cycles from the last accept to out_valid, then check and pop the result.
    task automatic result(input string tag, input logic [7:0] exp_data, input logic exp_sat,
                          input int exp_lat, input logic do_pop);
        int lat;
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, 32'(out_data), 32'(exp_data));
        check({tag, "_sat"}, 32'(out_sat), 32'(exp_sat));
        $display("txn %s: out_data=%02h out_sat=%0d latency=%0d", tag, out_data, out_sat, lat);
        if (do_pop) begin
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
            check({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_out_sat", 32'(out_sat), 32'd0);
        #11 rst = 1'b0;

        // 1.0 + 1.0 = 2.0; the MSB is bit 11, so latency is 2+11
        send(8'h38, 1'b0); send(8'h38, 1'b1);
        result("two_ones", 8'h40, 1'b0, 13, 1'b1);

        // 1.5 + 1.25 = 2.75
        send(8'h3C, 1'b0); send(8'h3A, 1'b1);
        result("sum_2p75", 8'h43, 1'b0, 13, 1'b1);

        // Terms cancel to zero
        send(8'h38, 1'b0); send(8'hB8, 1'b1);
        result("cancel", 8'h00, 1'b0, 2, 1'b1);

        // 16 x max: exponent overflow, but the accumulator does not clamp
        for (int i = 0; i < 16; i++) send(8'h7F, (i == 15));
        result("max16", 8'h7F, 1'b1, 2, 1'b1);

        // 18 x max: the accumulator clamps at 8388607
        for (int i = 0; i < 18; i++) send(8'h7F, (i == 17));
        result("max18", 8'h7F, 1'b1, 2, 1'b1);

        // 16 - 18 = -2 LSB: underflow gives +0 with no sat; MSB at bit 1
        send(8'h08, 1'b0); send(8'h89, 1'b1);
        result("underflow", 8'h00, 1'b0, 23, 1'b1);

        // Subnormal input is flushed to zero
        send(8'h05, 1'b1);
        result("subnormal", 8'h00, 1'b0, 2, 1'b1);

        // Backpressure: the result is held and input is refused
        send(8'h3C, 1'b0); send(8'h3A, 1'b1);
        result("hold", 8'h43, 1'b0, 13, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'hB8; in_last = 1'b1;
            @(posedge clk);
            #1;
            check("hold_data", 32'(out_data), 32'h43);
            check("hold_sat", 32'(out_sat), 32'd0);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        check("hold_release", 32'(in_ready), 32'd1);
        send(8'h38, 1'b0); send(8'h38, 1'b1);
        result("after_hold", 8'h40, 1'b0, 13, 1'b1);

        // Reset asserted mid-NORM at a random phase against the clock
        send(8'h08, 1'b1);
        repeat (5) @(posedge clk);
        #($urandom_range(1, 7));
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'h00);
        check("midrst_out_sat", 32'(out_sat), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send(8'h38, 1'b1);
        result("post_rst", 8'h38, 1'b0, 14, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
